// File: rtl/oled_spi_receiver.sv
// oled_spi_receiver
// Receive-side decoder for the 96x64 OLED pmod SPI link. It oversamples the
// cs/sclk/sdin/d_cn lines on the 100 MHz board clock and rebuilds command
// bytes and RGB565 pixels, each pixel tagged with its screen position.
//
// Ports:
//   clk, reset          board clock; synchronous active-high reset
//   cs, sdin, sclk, d_cn raw serial lines (cs active low, MSB first,
//                        sampled on sclk rising, d_cn=0 command / 1 data)
//   cmd_valid/cmd_byte   one-cycle pulse with the received command byte
//   pixel_valid          one-cycle pulse; pixel_data/pixel_index/x/y valid
//   frame_done           pulses together with the last pixel of a frame
//   byte_abort           pulses when cs rises with a partial byte received
module oled_spi_receiver #(
  parameter int WIDTH       = 96,
  parameter int HEIGHT      = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        sdin,
  input  logic        sclk,
  input  logic        d_cn,
  output logic        cmd_valid,
  output logic [7:0]  cmd_byte,
  output logic        pixel_valid,
  output logic [15:0] pixel_data,
  output logic [12:0] pixel_index,
  output logic [6:0]  x,
  output logic [5:0]  y,
  output logic        frame_done,
  output logic        byte_abort
);

  localparam logic [6:0] X_LAST = 7'(WIDTH - 1);
  localparam logic [5:0] Y_LAST = 6'(HEIGHT - 1);

  // Synchronizer chains, oldest stage at the top bit.
  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, sdin_sync, dcn_sync;
  logic                   cs_prev, sclk_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: cs resets to its idle (high) level so leaving reset never
      // looks like a cs edge or an open transfer.
      cs_sync   <= '1;
      sclk_sync <= '0;
      sdin_sync <= '0;
      dcn_sync  <= '0;
      cs_prev   <= 1'b1;
      sclk_prev <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      sdin_sync <= {sdin_sync[SYNC_STAGES-2:0], sdin};
      dcn_sync  <= {dcn_sync[SYNC_STAGES-2:0], d_cn};
      cs_prev   <= cs_sync[SYNC_STAGES-1];
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
    end
  end

  logic cs_s, sclk_s, sdin_s, dcn_s;
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign sdin_s = sdin_sync[SYNC_STAGES-1];
  assign dcn_s  = dcn_sync[SYNC_STAGES-1];

  logic sclk_rise, cs_rise, bit_take;
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign cs_rise   = cs_s & ~cs_prev;
  // A simultaneous cs rise already has cs_s high, so no bit is taken then.
  assign bit_take  = sclk_rise & ~cs_s;

  logic [6:0]  shreg;
  logic [2:0]  bit_cnt;
  logic [7:0]  rx_byte;
  logic [7:0]  hi_byte;
  logic        hi_pending;
  logic [6:0]  next_x;
  logic [5:0]  next_y;
  logic [12:0] next_index;

  // Byte as it stands once the bit arriving this cycle is shifted in.
  assign rx_byte = {shreg, sdin_s};

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg       <= '0;
      bit_cnt     <= '0;
      hi_byte     <= '0;
      hi_pending  <= 1'b0;
      next_x      <= '0;
      next_y      <= '0;
      next_index  <= '0;
      cmd_valid   <= 1'b0;
      cmd_byte    <= '0;
      pixel_valid <= 1'b0;
      pixel_data  <= '0;
      pixel_index <= '0;
      x           <= '0;
      y           <= '0;
      frame_done  <= 1'b0;
      byte_abort  <= 1'b0;
    end else begin
      // NOTE: every register here uses <= so all branches see the values
      // from before this edge; pulses default low and are raised below.
      cmd_valid   <= 1'b0;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      byte_abort  <= 1'b0;

      if (cs_rise) begin
        byte_abort <= (bit_cnt != 3'd0);
        bit_cnt    <= 3'd0;
      end else if (bit_take) begin
        shreg   <= rx_byte[6:0];
        bit_cnt <= bit_cnt + 3'd1;  // wraps 7 -> 0 on the last bit
        if (bit_cnt == 3'd7) begin
          if (!dcn_s) begin
            cmd_byte   <= rx_byte;
            cmd_valid  <= 1'b1;
            hi_pending <= 1'b0;
            next_x     <= '0;
            next_y     <= '0;
            next_index <= '0;
          end else if (!hi_pending) begin
            hi_byte    <= rx_byte;
            hi_pending <= 1'b1;
          end else begin
            pixel_data  <= {hi_byte, rx_byte};
            pixel_index <= next_index;
            x           <= next_x;
            y           <= next_y;
            pixel_valid <= 1'b1;
            hi_pending  <= 1'b0;
            // Raster advance; the linear index is counted alongside x/y.
            if (next_x == X_LAST) begin
              next_x <= '0;
              if (next_y == Y_LAST) begin
                next_y     <= '0;
                next_index <= '0;
                frame_done <= 1'b1;
              end else begin
                next_y     <= next_y + 6'd1;
                next_index <= next_index + 13'd1;
              end
            end else begin
              next_x     <= next_x + 7'd1;
              next_index <= next_index + 13'd1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_oled_spi_receiver.sv
// Testbench for oled_spi_receiver. A vector table plus streamed pixels feed
// a scoreboard queue; a negedge monitor pops and compares every DUT event.
// HEIGHT is reduced so a full frame wrap fits in a short run.
module tb_oled_spi_receiver;

  localparam int W    = 96;
  localparam int H    = 4;
  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        reset, cs, sdin, sclk, d_cn;
  logic        cmd_valid, pixel_valid, frame_done, byte_abort;
  logic [7:0]  cmd_byte;
  logic [15:0] pixel_data;
  logic [12:0] pixel_index;
  logic [6:0]  x;
  logic [5:0]  y;

  oled_spi_receiver #(.WIDTH(W), .HEIGHT(H), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .cs(cs), .sdin(sdin), .sclk(sclk), .d_cn(d_cn),
    .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .pixel_valid(pixel_valid),
    .pixel_data(pixel_data), .pixel_index(pixel_index), .x(x), .y(y),
    .frame_done(frame_done), .byte_abort(byte_abort)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_NONE, EV_CMD, EV_PIX, EV_ABORT} ev_kind_t;

  typedef struct {
    ev_kind_t    kind;
    logic [15:0] data;
    int          index;
    int          ex;
    int          ey;
    logic        frame;
  } ev_t;

  typedef struct {
    logic        dc;
    logic [7:0]  b;
    ev_kind_t    kind;
    logic [15:0] data;
    int          index;
  } vec_t;

  ev_t exp_q[$];
  int  n_vec = 0;
  int  n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor, sampling away from the active edge.
  always @(negedge clk) begin
    ev_kind_t act_kind;
    ev_t      e;
    if (cmd_valid | pixel_valid | byte_abort | frame_done) begin
      check("exclusive_pulse", $countones({cmd_valid, pixel_valid, byte_abort}), 1);
      act_kind = cmd_valid ? EV_CMD : pixel_valid ? EV_PIX : byte_abort ? EV_ABORT : EV_NONE;
      if (exp_q.size() == 0) begin
        check("unexpected_event", act_kind, EV_NONE);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", act_kind, e.kind);
        if (e.kind == EV_CMD) begin
          check("cmd_byte", cmd_byte, e.data[7:0]);
        end else if (e.kind == EV_PIX) begin
          check("pixel_data", pixel_data, e.data);
          check("pixel_index", pixel_index, e.index);
          check("pixel_x", x, e.ex);
          check("pixel_y", y, e.ey);
          check("frame_done", frame_done, e.frame);
        end
      end
    end
  end

  // Independent reference: a linear pixel counter with x/y from div/mod.
  logic       m_pend;
  logic [7:0] m_hi;
  int         m_pos;

  task automatic push_ev(input ev_kind_t k, input logic [15:0] d, input int idx);
    ev_t e;
    e.kind  = k;
    e.data  = d;
    e.index = idx;
    e.ex    = idx % W;
    e.ey    = idx / W;
    e.frame = (k == EV_PIX) && (idx == W * H - 1);
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    sdin = b;
    sclk = 1'b0;
    tick(3);
    sclk = 1'b1;
    tick(3);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) send_bit(b[i]);
  endtask

  task automatic send_byte(input logic dc, input logic [7:0] b);
    d_cn = dc;
    send_bits(b, 8);
  endtask

  task automatic tx_modeled(input logic dc, input logic [7:0] b);
    if (!dc) begin
      push_ev(EV_CMD, {8'h00, b}, 0);
      m_pend = 1'b0;
      m_pos  = 0;
    end else if (!m_pend) begin
      m_hi   = b;
      m_pend = 1'b1;
    end else begin
      push_ev(EV_PIX, {m_hi, b}, m_pos);
      m_pos  = (m_pos + 1) % (W * H);
      m_pend = 1'b0;
    end
    send_byte(dc, b);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_valid"}, cmd_valid, 0);
    check({tag, "_cmd_byte"}, cmd_byte, 0);
    check({tag, "_pixel_valid"}, pixel_valid, 0);
    check({tag, "_pixel_data"}, pixel_data, 0);
    check({tag, "_pixel_index"}, pixel_index, 0);
    check({tag, "_x"}, x, 0);
    check({tag, "_y"}, y, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_byte_abort"}, byte_abort, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[11];
    int   lat;

    vecs[0]  = '{1'b0, 8'h5A, EV_CMD,  16'h005A, 0};
    vecs[1]  = '{1'b1, 8'hF8, EV_NONE, 16'h0000, 0};
    vecs[2]  = '{1'b1, 8'h00, EV_PIX,  16'hF800, 0};
    vecs[3]  = '{1'b1, 8'h12, EV_NONE, 16'h0000, 0};
    vecs[4]  = '{1'b1, 8'h34, EV_PIX,  16'h1234, 1};
    vecs[5]  = '{1'b1, 8'hAB, EV_NONE, 16'h0000, 0};
    vecs[6]  = '{1'b0, 8'h3C, EV_CMD,  16'h003C, 0};
    vecs[7]  = '{1'b1, 8'h11, EV_NONE, 16'h0000, 0};
    vecs[8]  = '{1'b1, 8'h22, EV_PIX,  16'h1122, 0};
    vecs[9]  = '{1'b1, 8'h07, EV_NONE, 16'h0000, 0};
    vecs[10] = '{1'b1, 8'hE0, EV_PIX,  16'h07E0, 1};

    m_pend = 1'b0;
    m_hi   = 8'h00;
    m_pos  = 0;

    reset = 1'b1;
    cs    = 1'b1;
    sclk  = 1'b0;
    sdin  = 1'b0;
    d_cn  = 1'b0;
    tick(4);
    check_all_zero("reset");
    reset = 1'b0;
    tick(3);

    // First command byte with an exact latency check on the 8th bit.
    cs = 1'b0;
    tick(2);
    push_ev(EV_CMD, 16'h00AF, 0);
    d_cn = 1'b0;
    send_bits(8'hAF, 7);
    sdin = 1'b1;
    sclk = 1'b0;
    tick(3);
    sclk = 1'b1;
    lat  = 0;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      if (cmd_valid) begin
        lat = k;
        break;
      end
    end
    check("cmd_latency", lat, SYNC + 1);
    tick(1);
    check("cmd_pulse_width", cmd_valid, 0);
    tick(2);

    // Table-driven byte sequence.
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].kind != EV_NONE) push_ev(vecs[i].kind, vecs[i].data, vecs[i].index);
      send_byte(vecs[i].dc, vecs[i].b);
    end
    tick(10);

    // Partial byte then cs high: abort, then a clean byte.
    push_ev(EV_ABORT, 16'h0000, 0);
    d_cn = 1'b0;
    send_bits(8'hFF, 5);
    cs = 1'b1;
    tick(8);
    cs = 1'b0;
    tick(2);
    tx_modeled(1'b0, 8'hC3);
    tick(10);

    // 97 pixels: row wrap; cs toggled between halves of pixel 10.
    tx_modeled(1'b0, 8'hA5);
    for (int p = 0; p < 97; p++) begin
      logic [15:0] pd;
      pd = 16'($urandom);
      tx_modeled(1'b1, pd[15:8]);
      if (p == 10) begin
        cs = 1'b1;
        tick(6);
        cs = 1'b0;
        tick(2);
      end
      tx_modeled(1'b1, pd[7:0]);
    end
    tick(10);

    // Full frame plus one pixel: frame_done and wrap to index 0.
    tx_modeled(1'b0, 8'h81);
    for (int p = 0; p < W * H + 1; p++) begin
      logic [15:0] pd;
      pd = 16'($urandom) | 16'h0001;
      tx_modeled(1'b1, pd[15:8]);
      tx_modeled(1'b1, pd[7:0]);
    end
    tick(10);
    check("queue_drained_before_reset", exp_q.size(), 0);

    // Reset after a high byte and 3 bits of the low byte.
    send_byte(1'b1, 8'h55);
    send_bits(8'hAA, 3);
    reset = 1'b1;
    cs    = 1'b1;
    sclk  = 1'b0;
    tick(1);
    check_all_zero("midreset");
    reset = 1'b0;
    tick(4);
    cs = 1'b0;
    tick(2);
    push_ev(EV_PIX, 16'h07E0, 0);
    send_byte(1'b1, 8'h07);
    send_byte(1'b1, 8'hE0);
    tick(10);

    check("queue_drained_at_end", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
